// File: rtl/parity_rx_pkg.sv
// rtl/parity_rx_pkg.sv - shared constants and FSM state encodings for the parity frame receiver
package parity_rx_pkg;

   // Default frame geometry: data bits per frame and clk cycles per serial bit
   localparam int DATA_W_DEF       = 3;
   localparam int CLKS_PER_BIT_DEF = 4;

   // Width of the optional saturating error counter
   localparam int ERR_CNT_W = 8;

   // Receiver FSM states
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/rx_sync2.sv
// rtl/rx_sync2.sv - two-flop synchronizer for the idle-high serial line
module rx_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Resets to 1 so an idle line never looks like a start bit coming out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial frame receiver with even-parity and stop-bit checking (option: ERR_COUNT_EN)
module parity_frame_rx
   import parity_rx_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
`ifdef ERR_COUNT_EN
   output logic [ERR_CNT_W-1:0] err_count,
`endif
   output logic              busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_W + 1);

   // Start bit is checked mid-bit; every later sample lands one full bit period after it
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   logic              rx_s;
   logic [2:0]        state;
   logic [CW-1:0]     clk_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              par_bit;

   rx_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_in),
      .q   (rx_s)
   );

   assign busy = (state != ST_IDLE);

   // Frame FSM: walks start/data/parity/stop, sampling mid-bit, then strobes the result
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         clk_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (!rx_s) state <= ST_START;
            end
            ST_START: begin
               if (clk_cnt == HALF_M1) begin
                  clk_cnt <= '0;
                  // A line back high by mid-bit was a glitch, not a start bit
                  state   <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            ST_DATA: begin
               if (clk_cnt == BIT_END) begin
                  clk_cnt <= '0;
                  // LSB arrives first, so shift toward bit 0 and insert at the top
                  for (int i = 0; i < DATA_W - 1; i++) shreg[i] <= shreg[i+1];
                  shreg[DATA_W-1] <= rx_s;
                  bit_cnt <= bit_cnt + BW'(1);
                  if (bit_cnt == LAST_BIT) state <= ST_PARITY;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            ST_PARITY: begin
               if (clk_cnt == BIT_END) begin
                  clk_cnt <= '0;
                  par_bit <= rx_s;
                  state   <= ST_STOP;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            ST_STOP: begin
               if (clk_cnt == BIT_END) begin
                  clk_cnt    <= '0;
                  data_out   <= shreg;
                  parity_err <= (^shreg) ^ par_bit;
                  frame_err  <= ~rx_s;
                  data_valid <= 1'b1;
                  // Returning to IDLE right away lets a back-to-back start bit be caught
                  state      <= ST_IDLE;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ERR_COUNT_EN
   // Saturating count of delivered frames that carried any error
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (data_valid && (parity_err || frame_err) && (err_count != '1)) begin
         err_count <= err_count + ERR_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb/tb_parity_frame_rx.sv - directed self-checking bench for parity_frame_rx (DATA_W=3, CLKS_PER_BIT=4)
module tb_parity_frame_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic [2:0] data_out;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;
`ifdef ERR_COUNT_EN
   logic [7:0] err_count;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int n_pulses = 0;
   int n_double = 0;
   logic dv_prev = 1'b0;
   logic [4:0] rxq[$];

   parity_frame_rx #(.DATA_W(3), .CLKS_PER_BIT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
`ifdef ERR_COUNT_EN
      .err_count  (err_count),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Capture every strobe as {parity_err, frame_err, data_out}
   always @(negedge clk) begin
      if (data_valid) begin
         rxq.push_back({parity_err, frame_err, data_out});
         n_pulses = n_pulses + 1;
         if (dv_prev) n_double = n_double + 1;
      end
      dv_prev = data_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx_in = b;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_frame(input logic [2:0] d, input logic p, input logic s);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(s);
      rx_in = 1'b1;
   endtask

   task automatic expect_frame(input string tag, input logic [2:0] d, input logic pe, input logic fe);
      logic [4:0] e;
      check({tag, "_cnt"}, rxq.size(), 1);
      if (rxq.size() > 0) begin
         e = rxq.pop_front();
         check({tag, "_data"}, e[2:0], d);
         check({tag, "_perr"}, e[4], pe);
         check({tag, "_ferr"}, e[3], fe);
      end
   endtask

   initial begin
      logic saw_busy;
      logic [2:0] w;
      rst   = 1'b1;
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_dv", data_valid, 0);
      check("rst_data", data_out, 0);
      check("rst_perr", parity_err, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // 1: clean frame 101
      send_frame(3'b101, 1'b0, 1'b1);
      repeat (8) @(negedge clk);
      expect_frame("t1", 3'b101, 1'b0, 1'b0);
      check("t1_hold", data_out, 3'b101);

      // 2: wrong parity on 011
      send_frame(3'b011, 1'b1, 1'b1);
      repeat (8) @(negedge clk);
      expect_frame("t2", 3'b011, 1'b1, 1'b0);

      // 3: bad stop bit on 111
      send_frame(3'b111, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      expect_frame("t3", 3'b111, 1'b0, 1'b1);
      check("t3_ferr_hold", frame_err, 1);

      // 4: one-cycle glitch
      rx_in = 1'b0;
      @(negedge clk);
      rx_in = 1'b1;
      saw_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      check("t4_saw_busy", saw_busy, 1);
      check("t4_busy", busy, 0);
      check("t4_nopulse", rxq.size(), 0);
      check("t4_ferr_hold", frame_err, 1);

      // 5: reset in the middle of the data bits, then a clean frame
      send_bit(1'b0);
      send_bit(1'b0);
      check("t5_busy_pre", busy, 1);
      rst   = 1'b1;
      rx_in = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_data", data_out, 0);
      check("t5_ferr", frame_err, 0);
      check("t5_perr", parity_err, 0);
      check("t5_busy", busy, 0);
`ifdef ERR_COUNT_EN
      check("t5_errcnt", err_count, 0);
`endif
      repeat (4) @(negedge clk);
      check("t5_nopulse", rxq.size(), 0);
      send_frame(3'b110, 1'b0, 1'b1);
      repeat (8) @(negedge clk);
      expect_frame("t5", 3'b110, 1'b0, 1'b0);

      // 6: all eight words back to back
      for (int i = 0; i < 8; i++) begin
         w = 3'(i);
         send_frame(w, ^w, 1'b1);
      end
      repeat (8) @(negedge clk);
      check("t6_cnt", rxq.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (rxq.size() > 0) check($sformatf("t6_word%0d", i), rxq.pop_front(), 5'(i));
      end

`ifdef ERR_COUNT_EN
      for (int i = 0; i < 300; i++) send_frame(3'b000, 1'b1, 1'b1);
      repeat (8) @(negedge clk);
      check("errcnt_sat", err_count, 255);
      rxq.delete();
      check("pulses", n_pulses, 312);
`else
      check("pulses", n_pulses, 12);
`endif
      check("dv_width", n_double, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
